fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Instruction fetch front end of copperv. Sits directly upstream of the decoder and control unit.
- Issues sequential instruction-read requests on the ir bus channel (address/data valid-ready pairs).
- Buffers returned instruction words in a small FIFO and presents each word, with its pc, to the decode stage via a valid/ready handshake.
- Supports a single-cycle redirect (branch/jump target) that flushes buffered and in-flight fetches.

Parameters:
- pc_init, 0, pc after reset.
- pc_width, 32, width of pc and ir_addr.
- inst_width, 32, width of instruction words.
- fifo_depth, 2, FIFO entries; also the cap on (in-flight requests + buffered words). Must be a power of 2, ≥2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- ir_addr_valid  output  1  fetch address request valid.
- ir_addr_ready  input  1  bus accepts address.
- ir_addr  output  pc_width  fetch address.
- ir_data_valid  input  1  instruction data returned.
- ir_data_ready  output  1  unit accepts returned data.
- ir_data  input  inst_width  returned instruction word.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode consumes instruction.
- inst  output  inst_width  instruction word at FIFO head.
- inst_pc  output  pc_width  pc of inst.
- redirect  input  1  single-cycle pulse: flush, restart fetch at redirect_pc.
- redirect_pc  input  pc_width  new fetch pc; bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - state=state_reset; fetch_pc=pc_init; head_pc=pc_init.
  - count=0, outstanding=0, discard=0.
  - ir_addr_valid=0, ir_data_ready=0, inst_valid=0; inst and inst_pc are 0.
- FSM:
  - state_reset → state_idle on the first clk after rst deasserts.
  - state_idle → state_fetch on the next clk.
  - state_fetch is held until reset; there is no halt.
- Address issue:
  - ir_addr_valid = (state==state_fetch) && !redirect && (outstanding+count < fifo_depth).
  - ir_addr = fetch_pc.
  - Valid may drop without a handshake (copperv bus rule); the slave samples only on valid&&ready.
  - On addr_fire (valid&&ready): fetch_pc += 4, modulo 2^pc_width (wraps, no error); outstanding += 1.
- Data return:
  - ir_data_ready=1 in state_fetch. The credit rule guarantees FIFO space.
  - On data_fire: outstanding −= 1.
  - If discard>0: drop the word and discard −= 1.
  - Otherwise: push ir_data to the FIFO tail.
  - A pushed word appears on inst no earlier than the next cycle (no combinational bypass).
- Decode side:
  - inst_valid = (count>0) && !redirect.
  - inst/inst_pc come from the FIFO head; inst_pc = head_pc.
  - On pop (inst_valid&&inst_ready): head_pc += 4.
  - A push and a pop in the same cycle leave count unchanged.
  - Word order always matches request order; the bus returns data in order.
- Redirect (takes effect at the clock edge of the cycle where redirect=1):
  - FIFO flushed (count=0); fetch_pc=head_pc={redirect_pc[pc_width-1:2],2'b00}.
  - discard = outstanding − data_fire; any response arriving that cycle is dropped.
  - No request is issued and no pop occurs in the redirect cycle.
  - New requests may issue the following cycle, subject to credit (in-flight discards still hold credit).
  - redirect outside state_fetch is ignored.
- Counter widths: count, outstanding and discard are each clog2(fifo_depth+1) bits. The invariant outstanding+count ≤ fifo_depth must never be violated (assertion).
- Reset mid-operation: all state clears asynchronously. Responses to pre-reset requests are the bus's responsibility and are not tracked.

Test Plan:
- Reset with pc_init=0, ir_addr_ready=1, and data returned one cycle after each address:
  - ir_addr sequence 0x0, 0x4, 0x8, …; first ir_addr_valid in the 3rd cycle after rst falls.
  - inst/inst_pc pairs (word0,0x0), (word1,0x4) in order.
- Backpressure: inst_ready=0 with fifo_depth=2:
  - Exactly 2 requests issue; ir_addr_valid stays 0 afterwards.
  - Raising inst_ready for 1 cycle allows exactly 1 new request.
- Redirect with 2 requests in flight (0x8, 0xC) and redirect_pc=0x100:
  - Both late responses are dropped.
  - Next inst_pc=0x100 carries the word returned for ir_addr 0x100.
- Redirect in the same cycle as data_fire and inst_ready=1:
  - No pop.
  - Returned word discarded; discard = outstanding−1.
  - ir_addr=0x100 on the following cycle.
- Wrap: redirect_pc=0xFFFFFFFC:
  - ir_addr sequence 0xFFFFFFFC, 0x00000000; inst_pc follows identically.
- Async reset asserted mid-stream (count=2, outstanding=0):
  - inst_valid and ir_addr_valid fall immediately, without a clock edge.
  - Fetch restarts at pc_init.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: issues sequential reads on the ir bus and
// buffers returned words in a small FIFO. Each buffered word is handed to
// decode together with its pc. A redirect flushes the FIFO and any in-flight
// responses, then restarts fetch at a new pc.
module fetch_prefetch_unit #(
    parameter int unsigned            pc_width   = 32,
    parameter int unsigned            inst_width = 32,
    parameter int unsigned            fifo_depth = 2,
    parameter logic [pc_width-1:0]    pc_init    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [pc_width-1:0]   ir_addr,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready,
    input  logic [inst_width-1:0] ir_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [inst_width-1:0] inst,
    output logic [pc_width-1:0]   inst_pc,
    input  logic                  redirect,
    input  logic [pc_width-1:0]   redirect_pc
);

    localparam int CW = $clog2(fifo_depth + 1);
    localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam logic [CW:0]       DEPTH_C = (CW + 1)'(fifo_depth);
    localparam logic [pc_width-1:0] PC_STEP = pc_width'(4);

    typedef enum logic [1:0] {
        STATE_RESET = 2'd0,
        STATE_IDLE  = 2'd1,
        STATE_FETCH = 2'd2
    } state_t;

    state_t                state_q;
    logic [pc_width-1:0]   fetch_pc_q;
    logic [pc_width-1:0]   head_pc_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         outstanding_q;
    logic [CW-1:0]         discard_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW-1:0]         wr_ptr_q;
    logic [inst_width-1:0] mem_q [fifo_depth];

    logic                  fetching;
    logic                  redirect_act;
    logic                  addr_fire;
    logic                  data_fire;
    logic                  push;
    logic                  pop;
    logic [CW:0]           credit_used;
    logic [pc_width-1:0]   redirect_pc_al;
    logic [1:0]            unused_pc_lsbs;

    // Handshake decode: credit counts in-flight requests (discards included)
    // plus buffered words, so a returned word always has a FIFO slot.
    always_comb begin
        fetching       = (state_q == STATE_FETCH);
        redirect_act   = redirect && fetching;
        credit_used    = {1'b0, outstanding_q} + {1'b0, count_q};
        ir_addr_valid  = fetching && !redirect && (credit_used < DEPTH_C);
        ir_addr        = fetch_pc_q;
        ir_data_ready  = fetching;
        addr_fire      = ir_addr_valid && ir_addr_ready;
        data_fire      = ir_data_valid && ir_data_ready;
        push           = data_fire && !redirect_act && (discard_q == '0);
        inst_valid     = (count_q != '0) && !redirect;
        pop            = inst_valid && inst_ready;
        inst           = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        inst_pc        = head_pc_q;
        redirect_pc_al = {redirect_pc[pc_width-1:2], 2'b00};
        unused_pc_lsbs = redirect_pc[1:0];
    end

    // Control state: FSM, pcs, FIFO pointers and credit/discard counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= STATE_RESET;
            fetch_pc_q    <= pc_init;
            head_pc_q     <= pc_init;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            case (state_q)
                STATE_RESET: state_q <= STATE_IDLE;
                STATE_IDLE:  state_q <= STATE_FETCH;
                default:     state_q <= STATE_FETCH;
            endcase

            if (redirect_act) begin
                // Everything still owed by the bus becomes a discard; the
                // response landing this cycle (if any) is dropped right here.
                count_q       <= '0;
                rd_ptr_q      <= '0;
                wr_ptr_q      <= '0;
                fetch_pc_q    <= redirect_pc_al;
                head_pc_q     <= redirect_pc_al;
                outstanding_q <= outstanding_q - CW'(data_fire);
                discard_q     <= outstanding_q - CW'(data_fire);
            end else begin
                if (addr_fire) begin
                    fetch_pc_q <= fetch_pc_q + PC_STEP;
                end
                outstanding_q <= outstanding_q + CW'(addr_fire) - CW'(data_fire);
                if (data_fire && (discard_q != '0)) begin
                    discard_q <= discard_q - CW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop);
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q  <= rd_ptr_q + AW'(1);
                    head_pc_q <= head_pc_q + PC_STEP;
                end
            end
        end
    end

    // FIFO storage: data only, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ir_data;
        end
    end

    // Credit invariant: never more requests plus buffered words than slots.
    a_credit: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, outstanding_q} + {1'b0, count_q}) <= DEPTH_C);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order bus responder and
// a queue-based reference model checked every cycle.
module tb_fetch_prefetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_addr_valid, ir_addr_ready;
    logic [31:0] ir_addr;
    logic        ir_data_valid, ir_data_ready;
    logic [31:0] ir_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .pc_width  (32),
        .inst_width(32),
        .fifo_depth(DEPTH),
        .pc_init   (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ir_addr_valid(ir_addr_valid),
        .ir_addr_ready(ir_addr_ready),
        .ir_addr      (ir_addr),
        .ir_data_valid(ir_data_valid),
        .ir_data_ready(ir_data_ready),
        .ir_data      (ir_data),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    typedef struct { logic [31:0] addr; bit disc; } req_t;
    typedef struct { logic [31:0] w; logic [31:0] pc; } ent_t;

    // Reference model: requests owed by the bus (in order) and buffered words.
    req_t        inflight[$];
    ent_t        fifo[$];
    int          m_state;
    logic [31:0] m_fpc;

    // What the DUT was seen to do, for literal checks.
    logic [31:0] fire_addrs[$];
    logic [31:0] pop_pcs[$];
    logic [31:0] pop_ws[$];

    bit          s_rdy, s_irdy, s_redir, s_resp;
    logic [31:0] s_rpc;

    int checks = 0, passed = 0, fails = 0;

    function automatic logic [31:0] word(logic [31:0] a);
        return a ^ 32'h13579BDF;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit   e_av, e_dr, e_iv, afire, dfire, popm;
        req_t r;
        ent_t e;
        @(negedge clk);
        inst_ready    = s_rdy;
        ir_addr_ready = s_irdy;
        redirect      = s_redir;
        redirect_pc   = s_rpc;
        ir_data_valid = s_resp && (inflight.size() > 0);
        ir_data       = ir_data_valid ? word(inflight[0].addr) : 32'hDEADBEEF;
        #1;
        e_av = (m_state == 2) && !s_redir && (inflight.size() + fifo.size() < DEPTH);
        e_dr = (m_state == 2);
        e_iv = (fifo.size() > 0) && !s_redir;
        chk("ir_addr_valid", 32'(ir_addr_valid), 32'(e_av));
        if (e_av) chk("ir_addr", ir_addr, m_fpc);
        chk("ir_data_ready", 32'(ir_data_ready), 32'(e_dr));
        chk("inst_valid", 32'(inst_valid), 32'(e_iv));
        if (e_iv) begin
            chk("inst", inst, fifo[0].w);
            chk("inst_pc", inst_pc, fifo[0].pc);
        end
        afire = e_av && s_irdy;
        dfire = e_dr && ir_data_valid;
        popm  = e_iv && s_rdy;
        if (ir_addr_valid && ir_addr_ready) fire_addrs.push_back(ir_addr);
        if (inst_valid && inst_ready) begin
            pop_pcs.push_back(inst_pc);
            pop_ws.push_back(inst);
        end
        @(posedge clk);
        if (m_state < 2) begin
            m_state++;
        end else if (s_redir) begin
            if (dfire) void'(inflight.pop_front());
            foreach (inflight[i]) inflight[i].disc = 1'b1;
            fifo.delete();
            m_fpc = {s_rpc[31:2], 2'b00};
        end else begin
            if (popm) void'(fifo.pop_front());
            if (dfire) begin
                r = inflight.pop_front();
                if (!r.disc) begin
                    e.w  = word(r.addr);
                    e.pc = r.addr;
                    fifo.push_back(e);
                end
            end
            if (afire) begin
                r.addr = m_fpc;
                r.disc = 1'b0;
                inflight.push_back(r);
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_obs();
        fire_addrs.delete();
        pop_pcs.delete();
        pop_ws.delete();
    endtask

    task automatic drain();
        s_irdy = 0; s_rdy = 1; s_resp = 1; s_redir = 0;
        run(6);
    endtask

    // Asynchronous reset in the middle of a low clock phase.
    task automatic do_reset(bit live);
        @(negedge clk);
        #1;
        if (live) begin
            chk("pre-reset inst_valid", 32'(inst_valid), 32'd1);
            chk("pre-reset ir_addr_valid", 32'(ir_addr_valid), 32'd0);
        end
        #1;
        rst = 1'b1;
        #1;
        chk("rst ir_addr_valid", 32'(ir_addr_valid), 32'd0);
        chk("rst ir_data_ready", 32'(ir_data_ready), 32'd0);
        chk("rst inst_valid", 32'(inst_valid), 32'd0);
        chk("rst inst", inst, 32'd0);
        chk("rst inst_pc", inst_pc, 32'd0);
        inflight.delete();
        fifo.delete();
        m_state = 0;
        m_fpc   = 32'h0;
        ir_data_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ir_addr_ready = 0; ir_data_valid = 0; ir_data = '0;
        inst_ready = 0; redirect = 0; redirect_pc = '0;
        s_rdy = 1; s_irdy = 1; s_redir = 0; s_resp = 1; s_rpc = '0;
        m_state = 0; m_fpc = 32'h0;
        #1;
        chk("reset ir_addr_valid", 32'(ir_addr_valid), 32'd0);
        chk("reset inst_valid", 32'(inst_valid), 32'd0);
        chk("reset inst", inst, 32'd0);
        chk("reset inst_pc", inst_pc, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sequential fetch after reset, one-cycle response latency.
        clear_obs();
        run(2);
        chk("no fetch before 3rd cycle", 32'(fire_addrs.size()), 32'd0);
        run(4);
        chk("seq fires", 32'(fire_addrs.size()), 32'd3);
        if (fire_addrs.size() >= 3) begin
            chk("seq addr0", fire_addrs[0], 32'h0);
            chk("seq addr1", fire_addrs[1], 32'h4);
            chk("seq addr2", fire_addrs[2], 32'h8);
        end
        chk("seq pops", 32'(pop_pcs.size()), 32'd2);
        if (pop_pcs.size() >= 2) begin
            chk("seq pc0", pop_pcs[0], 32'h0);
            chk("seq word0", pop_ws[0], 32'h13579BDF);
            chk("seq pc1", pop_pcs[1], 32'h4);
            chk("seq word1", pop_ws[1], 32'h13579BDB);
        end

        // Backpressure: decode stalled, then flushed to a clean start.
        s_rdy = 0;
        run(8);
        #1;
        chk("bp full addr_valid", 32'(ir_addr_valid), 32'd0);
        clear_obs();
        s_redir = 1; s_rpc = 32'h40;
        cycle();
        s_redir = 0;
        run(6);
        chk("bp fire count", 32'(fire_addrs.size()), 32'd2);
        if (fire_addrs.size() >= 2) begin
            chk("bp addr0", fire_addrs[0], 32'h40);
            chk("bp addr1", fire_addrs[1], 32'h44);
        end
        #1;
        chk("bp stalled addr_valid", 32'(ir_addr_valid), 32'd0);
        clear_obs();
        s_rdy = 1;
        cycle();
        s_rdy = 0;
        run(5);
        chk("bp one credit", 32'(fire_addrs.size()), 32'd1);
        if (fire_addrs.size() >= 1) chk("bp credit addr", fire_addrs[0], 32'h48);

        // Redirect with two requests in flight.
        drain();
        clear_obs();
        s_irdy = 1; s_resp = 0; s_redir = 1; s_rpc = 32'h8;
        cycle();
        s_redir = 0;
        run(3);
        chk("inflight fires", 32'(fire_addrs.size()), 32'd2);
        if (fire_addrs.size() >= 2) begin
            chk("inflight addr0", fire_addrs[0], 32'h8);
            chk("inflight addr1", fire_addrs[1], 32'hC);
        end
        s_redir = 1; s_rpc = 32'h100;
        cycle();
        s_redir = 0; s_resp = 1;
        clear_obs();
        for (int i = 0; i < 12 && pop_pcs.size() == 0; i++) cycle();
        chk("redir pop seen", 32'(pop_pcs.size() > 0), 32'd1);
        if (pop_pcs.size() > 0) begin
            chk("redir first pc", pop_pcs[0], 32'h100);
            chk("redir first word", pop_ws[0], 32'h13579ADF);
        end

        // Redirect coinciding with a returned word and a ready decoder.
        drain();
        s_irdy = 1; s_resp = 0; s_redir = 1; s_rpc = 32'h20;
        cycle();
        s_redir = 0;
        run(2);
        s_resp = 1;
        cycle();
        clear_obs();
        s_redir = 1; s_rpc = 32'h100; s_rdy = 1;
        cycle();
        chk("same-cycle no pop", 32'(pop_pcs.size()), 32'd0);
        s_redir = 0;
        cycle();
        chk("same-cycle next fire", 32'(fire_addrs.size()), 32'd1);
        if (fire_addrs.size() >= 1) chk("same-cycle next addr", fire_addrs[0], 32'h100);
        run(4);

        // PC wrap at the top of the address space.
        drain();
        clear_obs();
        s_irdy = 1; s_resp = 1; s_rdy = 1; s_redir = 1; s_rpc = 32'hFFFFFFFE;
        cycle();
        s_redir = 0;
        run(8);
        chk("wrap fires", 32'(fire_addrs.size() >= 2), 32'd1);
        if (fire_addrs.size() >= 2) begin
            chk("wrap addr0", fire_addrs[0], 32'hFFFFFFFC);
            chk("wrap addr1", fire_addrs[1], 32'h0);
        end
        chk("wrap pops", 32'(pop_pcs.size() >= 2), 32'd1);
        if (pop_pcs.size() >= 2) begin
            chk("wrap pc0", pop_pcs[0], 32'hFFFFFFFC);
            chk("wrap pc1", pop_pcs[1], 32'h0);
        end

        // Asynchronous reset with a full FIFO and nothing in flight.
        s_rdy = 0; s_irdy = 1; s_resp = 1;
        run(8);
        do_reset(1'b1);
        clear_obs();
        s_rdy = 1;
        run(3);
        chk("post-reset fires", 32'(fire_addrs.size()), 32'd1);
        if (fire_addrs.size() >= 1) chk("post-reset addr", fire_addrs[0], 32'h0);
        run(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
